// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order instruction prefetch FIFO between program memory and the IF stage.
// Optional build macro FETCH_BUFFER_BYPASS_EN: a response arriving while the FIFO is empty
// is presented to the IF stage in the same cycle and is not stored if consumed there.
module fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        flush,
    input  logic [31:0] flushPC,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memGnt,
    input  logic        memRvalid,
    input  logic [31:0] memRdata,
    output logic        instValid,
    output logic [31:0] instOut,
    output logic [31:0] PCout,
    input  logic        instReady
);
    localparam int          AW       = $clog2(DEPTH);
    localparam int          CW       = AW + 1;
    localparam logic [CW:0] DEPTH_W  = (CW + 1)'(DEPTH);
    localparam logic [31:0] RESET_AL = RESET_PC & ~32'h3;
    localparam logic [0:0]  FETCH    = 1'b0;
    localparam logic [0:0]  DRAIN    = 1'b1;

    logic [0:0]    state_q, state_d;
    logic          run_q;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   pc_mem_q   [DEPTH];

    logic          in_fetch;
    logic          fifo_empty;
    logic          accept;
    logic          bypass;
    logic          push;
    logic          pop;
    logic [31:0]   flush_pc;

    assign flush_pc = flushPC & ~32'h3;

    // Request gating, handshakes and the IF-side view of the head entry (or bypassed response).
    always_comb begin
        in_fetch   = state_q == FETCH;
        fifo_empty = count_q == '0;
        memReq     = run_q && in_fetch && !flush && (({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_W);
        memAddr    = fetch_pc_q;
        accept     = memReq && memGnt;
`ifdef FETCH_BUFFER_BYPASS_EN
        bypass     = run_q && in_fetch && fifo_empty && memRvalid && !flush;
`else
        bypass     = 1'b0;
`endif
        instValid  = !fifo_empty || bypass;
        instOut    = !fifo_empty ? inst_mem_q[rd_ptr_q] : bypass ? memRdata : '0;
        PCout      = !fifo_empty ? pc_mem_q[rd_ptr_q] : bypass ? resp_pc_q : '0;
        pop        = !flush && !fifo_empty && instReady;
        push       = !flush && in_fetch && memRvalid && !(bypass && instReady);
    end

    // Next-state: flush empties the FIFO, redirects both PCs and turns in-flight requests into discards.
    always_comb begin
        outst_d    = outst_q + CW'(accept) - CW'(memRvalid);
        fetch_pc_d = flush ? flush_pc : accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
        resp_pc_d  = flush ? flush_pc : (in_fetch && memRvalid) ? resp_pc_q + 32'd4 : resp_pc_q;
        count_d    = flush ? '0 : count_q + CW'(push) - CW'(pop);
        rd_ptr_d   = flush ? '0 : rd_ptr_q + AW'(pop);
        wr_ptr_d   = flush ? '0 : wr_ptr_q + AW'(push);
        discard_d  = flush ? outst_d : (!in_fetch && memRvalid) ? discard_q - CW'(1) : discard_q;
        state_d    = flush ? ((outst_d != '0) ? DRAIN : FETCH)
                   : (!in_fetch && discard_d == '0) ? FETCH : state_q;
    end

    // Control state; reset drops every in-flight request and buffered entry at once.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q    <= FETCH;
            run_q      <= 1'b0;
            fetch_pc_q <= RESET_AL;
            resp_pc_q  <= RESET_AL;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Entry storage is unreset: outputs are masked whenever count is zero.
    always_ff @(posedge Clock) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= memRdata;
            pc_mem_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

    a_rvalid_has_outstanding: assert property (@(posedge Clock) disable iff (!nReset)
        memRvalid |-> outst_q != '0);

    a_no_overcommit: assert property (@(posedge Clock) disable iff (!nReset)
        ({1'b0, count_q} + {1'b0, outst_q}) <= DEPTH_W);

    a_drain_matches_outstanding: assert property (@(posedge Clock) disable iff (!nReset)
        state_q == DRAIN |-> discard_q == outst_q);

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: scenario tasks plus randomized traffic against a queue-based reference model.
module tb_fetch_buffer;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_BUFFER_BYPASS_EN
    localparam int          LAT    = 1;
`else
    localparam int          LAT    = 2;
`endif

    logic        Clock = 1'b0;
    logic        nReset = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flushPC = '0;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memGnt = 1'b0;
    logic        memRvalid = 1'b0;
    logic [31:0] memRdata = '0;
    logic        instValid;
    logic [31:0] instOut;
    logic [31:0] PCout;
    logic        instReady = 1'b0;

    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .Clock(Clock), .nReset(nReset), .flush(flush), .flushPC(flushPC),
        .memReq(memReq), .memAddr(memAddr), .memGnt(memGnt), .memRvalid(memRvalid),
        .memRdata(memRdata), .instValid(instValid), .instOut(instOut), .PCout(PCout),
        .instReady(instReady)
    );

    always #5 Clock = ~Clock;

    typedef struct { logic [31:0] addr; bit stale; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

    req_t        pend[$];
    ent_t        fifo[$];
    logic [31:0] nxt_pc;
    bit          started;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        o_req, o_valid, e_req, e_valid;
    logic [31:0] o_addr, o_inst, o_pc, e_addr, e_inst, e_pc;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A17 ^ (a << 7);
    endfunction

    task automatic model_reset();
        pend.delete();
        fifo.delete();
        nxt_pc  = RST_PC;
        started = 1'b0;
    endtask

    // One clock: drive at negedge, sample outputs, then advance the model past the coming edge.
    task automatic step(input bit f, input logic [31:0] fpc, input bit g, input bit r_en, input bit rdy);
        bit   rv, byp, hst;
        ent_t ent;
        @(negedge Clock);
        flush = f; flushPC = fpc; memGnt = g; instReady = rdy;
        rv = r_en && pend.size() != 0;
        memRvalid = rv;
        memRdata  = rv ? mem_data(pend[0].addr) : 32'h0;
        hst = rv ? pend[0].stale : 1'b1;
        ent.pc   = rv ? pend[0].addr : 32'h0;
        ent.data = memRdata;
        byp = 1'b0;
`ifdef FETCH_BUFFER_BYPASS_EN
        byp = started && !f && fifo.size() == 0 && rv && !hst;
`endif
        e_req   = started && !f && (fifo.size() + pend.size() < DEPTH) && !(pend.size() != 0 && pend[0].stale);
        e_addr  = nxt_pc;
        e_valid = fifo.size() != 0 || byp;
        e_pc    = fifo.size() != 0 ? fifo[0].pc : byp ? ent.pc : 32'h0;
        e_inst  = fifo.size() != 0 ? fifo[0].data : byp ? ent.data : 32'h0;
        #1;
        o_req = memReq; o_addr = memAddr; o_valid = instValid; o_pc = PCout; o_inst = instOut;
        if (rv) void'(pend.pop_front());
        if (f) begin
            fifo.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            nxt_pc = fpc & ~32'h3;
        end else begin
            if (e_valid && rdy && fifo.size() != 0) void'(fifo.pop_front());
            if (rv && !hst && !(byp && rdy)) fifo.push_back(ent);
            if (e_req && g) begin
                pend.push_back('{addr: nxt_pc, stale: 1'b0});
                nxt_pc += 32'd4;
            end
        end
        started = 1'b1;
        cyc++;
    endtask

    task automatic do_reset();
        nReset = 1'b0; flush = 0; memGnt = 0; memRvalid = 0; instReady = 0; flushPC = '0; memRdata = '0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1 nReset = 1'b1;
    endtask

    task automatic test_reset();
        nReset = 1'b0; flush = 0; instReady = 1;
        memGnt = 1; memRvalid = 1; memRdata = 32'hDEAD_BEEF;
        model_reset();
        repeat (3) @(posedge Clock);
        #1;
        checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL rst_memReq got %b exp 0", memReq); end
        checks++; if (memAddr !== RST_PC) begin errors++; $display("FAIL rst_memAddr got %h exp %h", memAddr, RST_PC); end
        checks++; if (instValid !== 1'b0) begin errors++; $display("FAIL rst_instValid got %b exp 0", instValid); end
        checks++; if (instOut !== 32'h0) begin errors++; $display("FAIL rst_instOut got %h exp 0", instOut); end
        checks++; if (PCout !== 32'h0) begin errors++; $display("FAIL rst_PCout got %h exp 0", PCout); end
        memGnt = 0; memRvalid = 0; memRdata = '0;
        #1 nReset = 1'b1;
        step(0, 0, 1, 1, 1);
        checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL rst_req_before_edge got %b exp 0", o_req); end
        step(0, 0, 1, 1, 1);
        checks++; if (o_req !== 1'b1) begin errors++; $display("FAIL rst_first_req got %b exp 1", o_req); end
        checks++; if (o_addr !== RST_PC) begin errors++; $display("FAIL rst_first_addr got %h exp %h", o_addr, RST_PC); end
    endtask

    task automatic test_stream();
        int gc = -1, vc = -1, n = 0;
        logic [31:0] pcs[4], ins[4];
        do_reset();
        for (int i = 0; i < 40 && n < 4; i++) begin
            step(0, 0, 1, 1, 1);
            if (gc < 0 && o_req) gc = i;
            if (vc < 0 && o_valid) vc = i;
            if (o_valid) begin pcs[n] = o_pc; ins[n] = o_inst; n++; end
        end
        checks++; if (n != 4) begin errors++; $display("FAIL stream_count got %0d exp 4", n); end
        checks++; if (vc - gc != LAT) begin errors++; $display("FAIL stream_latency got %0d exp %0d", vc - gc, LAT); end
        for (int k = 0; k < n; k++) begin
            checks++; if (pcs[k] !== 32'(4 * k)) begin errors++; $display("FAIL stream_pc%0d got %h exp %h", k, pcs[k], 32'(4 * k)); end
            checks++; if (ins[k] !== mem_data(32'(4 * k))) begin errors++; $display("FAIL stream_inst%0d got %h exp %h", k, ins[k], mem_data(32'(4 * k))); end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_reset();
        repeat (12) begin
            step(0, 0, 1, 1, 0);
            if (o_req) n++;
        end
        checks++; if (n != DEPTH) begin errors++; $display("FAIL bp_requests got %0d exp %0d", n, DEPTH); end
        checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL bp_req_low got %b exp 0", o_req); end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", o_valid); end
        checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL bp_pc_hold got %h exp 0", o_pc); end
        step(0, 0, 1, 1, 1);
        checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL bp_pop0 got %h exp 0", o_pc); end
        step(0, 0, 1, 1, 1);
        checks++; if (o_pc !== 32'h4) begin errors++; $display("FAIL bp_pop1 got %h exp 4", o_pc); end
    endtask

    task automatic test_flush_drain();
        bit seen = 0;
        do_reset();
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        step(1, 32'h100, 0, 0, 1);
        checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL fd_flush_req got %b exp 0", o_req); end
        repeat (2) begin
            step(0, 0, 1, 1, 1);
            checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL fd_drain_req got %b exp 0", o_req); end
            checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL fd_drain_valid got %b exp 0", o_valid); end
        end
        step(0, 0, 1, 1, 1);
        checks++; if (o_req !== 1'b1) begin errors++; $display("FAIL fd_resume_req got %b exp 1", o_req); end
        checks++; if (o_addr !== 32'h100) begin errors++; $display("FAIL fd_resume_addr got %h exp 100", o_addr); end
        for (int i = 0; i < 8 && !seen; i++) begin
            step(0, 0, 1, 1, 1);
            seen = o_valid;
        end
        checks++; if (!seen || o_pc !== 32'h100) begin errors++; $display("FAIL fd_first_pc got %h valid %b exp 100", o_pc, seen); end
        checks++; if (o_inst !== mem_data(32'h100)) begin errors++; $display("FAIL fd_first_inst got %h exp %h", o_inst, mem_data(32'h100)); end
    endtask

    task automatic test_flush_grant();
        bit seen = 0;
        do_reset();
        repeat (3) step(0, 0, 1, 1, 0);
        step(1, 32'h200, 1, 0, 1);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL fg_valid_at_flush got %b exp 1", o_valid); end
        step(0, 0, 0, 0, 1);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL fg_empty_after got %b exp 0", o_valid); end
        checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL fg_drain_req got %b exp 0", o_req); end
        for (int i = 0; i < 12 && !seen; i++) begin
            step(0, 0, 1, 1, 1);
            seen = o_valid;
        end
        checks++; if (!seen || o_pc !== 32'h200) begin errors++; $display("FAIL fg_first_pc got %h valid %b exp 200", o_pc, seen); end
    endtask

    task automatic test_wrap();
        int na = 0, np = 0;
        logic [31:0] addrs[2], pcs[2];
        do_reset();
        step(0, 0, 0, 0, 1);
        step(1, 32'hFFFF_FFFC, 0, 0, 1);
        for (int i = 0; i < 10 && np < 2; i++) begin
            step(0, 0, 1, 1, 1);
            if (o_req && na < 2) begin addrs[na] = o_addr; na++; end
            if (o_valid && np < 2) begin pcs[np] = o_pc; np++; end
        end
        checks++; if (na != 2 || addrs[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0 got %h exp fffffffc", addrs[0]); end
        checks++; if (na != 2 || addrs[1] !== 32'h0) begin errors++; $display("FAIL wrap_addr1 got %h exp 0", addrs[1]); end
        checks++; if (np != 2 || pcs[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0 got %h exp fffffffc", pcs[0]); end
        checks++; if (np != 2 || pcs[1] !== 32'h0) begin errors++; $display("FAIL wrap_pc1 got %h exp 0", pcs[1]); end
    endtask

    task automatic test_async_reset();
        bit seen = 0;
        do_reset();
        step(0, 0, 0, 0, 0);
        repeat (4) step(0, 0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 1, 0);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL ar_valid_before got %b exp 1", o_valid); end
        #2;
        memRvalid = 0; memGnt = 0; instReady = 1; nReset = 1'b0;
        #1;
        checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL ar_memReq got %b exp 0", memReq); end
        checks++; if (memAddr !== RST_PC) begin errors++; $display("FAIL ar_memAddr got %h exp %h", memAddr, RST_PC); end
        checks++; if (instValid !== 1'b0) begin errors++; $display("FAIL ar_instValid got %b exp 0", instValid); end
        checks++; if (instOut !== 32'h0) begin errors++; $display("FAIL ar_instOut got %h exp 0", instOut); end
        checks++; if (PCout !== 32'h0) begin errors++; $display("FAIL ar_PCout got %h exp 0", PCout); end
        model_reset();
        repeat (2) @(posedge Clock);
        #1 nReset = 1'b1;
        step(0, 0, 1, 1, 1);
        checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL ar_req_before_edge got %b exp 0", o_req); end
        step(0, 0, 1, 1, 1);
        checks++; if (o_req !== 1'b1 || o_addr !== RST_PC) begin errors++; $display("FAIL ar_restart got req %b addr %h exp 1 %h", o_req, o_addr, RST_PC); end
        for (int i = 0; i < 8 && !seen; i++) begin
            step(0, 0, 1, 1, 1);
            seen = o_valid;
        end
        checks++; if (!seen || o_pc !== RST_PC) begin errors++; $display("FAIL ar_first_pc got %h valid %b exp %h", o_pc, seen, RST_PC); end
    endtask

    task automatic test_random();
        bit f, g, r, rdy;
        logic [31:0] fpc;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            f   = ($urandom % 40) == 0;
            fpc = ($urandom % 4 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
            g   = $urandom % 2;
            r   = ($urandom % 10) < 6;
            rdy = ($urandom % 10) < 6;
            step(f, fpc, g, r, rdy);
            checks++; if (o_req !== e_req) begin errors++; $display("FAIL rnd_req cyc %0d got %b exp %b", cyc, o_req, e_req); end
            if (e_req) begin
                checks++; if (o_addr !== e_addr) begin errors++; $display("FAIL rnd_addr cyc %0d got %h exp %h", cyc, o_addr, e_addr); end
            end
            checks++; if (o_valid !== e_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, o_valid, e_valid); end
            if (e_valid) begin
                checks++; if (o_pc !== e_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h exp %h", cyc, o_pc, e_pc); end
                checks++; if (o_inst !== e_inst) begin errors++; $display("FAIL rnd_inst cyc %0d got %h exp %h", cyc, o_inst, e_inst); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_drain();
        test_flush_grant();
        test_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; power of two, >=2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 Clock  input  1  single clock, all state on rising edge.
REQ-004 nReset  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  redirect request from the branch unit.
REQ-006 flushPC  input  32  new fetch address, sampled when flush=1.
REQ-007 memReq  output  1  fetch request to program memory.
REQ-008 memAddr  output  32  word-aligned fetch address.
REQ-009 memGnt  input  1  request accepted this cycle.
REQ-010 memRvalid  input  1  read data valid; responses return in request order.
REQ-011 memRdata  input  32  returned instruction word.
REQ-012 instValid  output  1  head entry valid towards IF stage.
REQ-013 instOut  output  32  head instruction.
REQ-014 PCout  output  32  PC of head instruction.
REQ-015 instReady  input  1  IF stage consumes head when instValid&instReady.

Function
REQ-016 FSM SHALL have states FETCH and DRAIN; reset state FETCH.
REQ-017 Request accepted SHALL mean memReq&memGnt; fetchPC SHALL then increment by 4 (mod 2^32 wrap).
REQ-018 memReq SHALL assert in FETCH only when count+outstanding < DEPTH and flush=0.
REQ-019 Once asserted, memReq and memAddr SHALL hold stable until memGnt, except withdrawal on flush.
REQ-020 outstanding SHALL count accepted requests not yet answered; max DEPTH.
REQ-021 Each memRvalid in FETCH SHALL push {respPC, memRdata}; respPC then increments by 4.
REQ-022 Push and pop in same cycle SHALL keep count unchanged; no overflow possible by REQ-018.
REQ-023 instValid SHALL equal count!=0 (see REQ-033 for bypass).
REQ-024 On flush: FIFO emptied, fetchPC and respPC <= flushPC, pop ignored, no request issued that cycle.
REQ-025 On flush, discard counter SHALL load outstanding after this cycle's grant/response; state -> DRAIN if nonzero, else FETCH.
REQ-026 In DRAIN each memRvalid SHALL decrement discard and SHALL NOT push; memReq=0.
REQ-027 DRAIN -> FETCH the cycle after discard reaches 0.
REQ-028 Flush during DRAIN SHALL reload discard per REQ-025 and reload fetchPC/respPC.
REQ-029 memRvalid with outstanding=0 is illegal; assertion SHALL flag it in simulation.

Reset
REQ-030 While nReset=0: memReq=0, memAddr=RESET_PC, instValid=0, instOut=0, PCout=0, count/outstanding/discard=0, state FETCH.
REQ-031 First memReq SHALL assert the first rising edge after nReset release, memAddr=RESET_PC.
REQ-032 Reset mid-transaction SHALL drop all in-flight state; memory side is reset with the core.

Configuration
REQ-033 Macro FETCH_BUFFER_BYPASS_EN defined: when FIFO empty, state FETCH and memRvalid=1, instValid=1 same cycle with instOut=memRdata, PCout=respPC; if instReady=1, entry is not written.
REQ-034 Macro absent: instValid asserts no earlier than the cycle after memRvalid (1-cycle minimum latency).

Verification
REQ-035 Reset release, memGnt=1, memRvalid 1 cycle after grant, instReady=1 -> PCout sequence 0x0,0x4,0x8,0xC; latency 2 cycles (1 with bypass).
REQ-036 instReady=0, memory always ready -> exactly DEPTH=4 requests, memReq then 0; instValid held with PCout=0x0 until instReady.
REQ-037 Two requests outstanding, flush with flushPC=0x100 -> both stale responses dropped, DRAIN 2 responses, next memAddr=0x100, first PCout=0x100.
REQ-038 Flush same cycle as memGnt and instReady -> granted request counted stale, pop ignored, FIFO empty next cycle.
REQ-039 flushPC=0xFFFF_FFFC -> memAddr sequence 0xFFFF_FFFC, 0x0000_0000 (wrap).
REQ-040 nReset asserted with 3 entries and 1 outstanding -> all outputs at reset values asynchronously; restart at RESET_PC.
